// File: rtl/linear_driver_if.sv
// Bundle of the load stream, linear-unit operand/result ports and result stream
// seen by linear_driver; the driver uses the master view, its environment the slave view.
interface linear_driver_if #(
    parameter int D_IN  = 4,
    parameter int D_OUT = 2,
    parameter int DW    = 4,
    parameter int ACC_W = 2*DW + $clog2(D_IN)
);
    logic                    ld_valid;
    logic                    ld_ready;
    logic [ACC_W-1:0]        ld_data;

    logic                    lu_start;
    logic                    lu_in_valid;
    logic signed [DW-1:0]    lu_in_vec [0:D_IN-1];
    logic signed [DW-1:0]    lu_w_mat  [0:D_OUT*D_IN-1];
    logic signed [ACC_W-1:0] lu_b_vec  [0:D_OUT-1];
    logic                    lu_out_valid;
    logic signed [ACC_W-1:0] lu_out_vec [0:D_OUT-1];

    logic                    res_valid;
    logic                    res_ready;
    logic [ACC_W-1:0]        res_data;
    logic                    res_last;

    logic                    busy;
    logic                    timeout_err;

    modport master (
        input  ld_valid, ld_data, lu_out_valid, lu_out_vec, res_ready,
        output ld_ready, lu_start, lu_in_valid, lu_in_vec, lu_w_mat, lu_b_vec,
               res_valid, res_data, res_last, busy, timeout_err
    );

    modport slave (
        output ld_valid, ld_data, lu_out_valid, lu_out_vec, res_ready,
        input  ld_ready, lu_start, lu_in_valid, lu_in_vec, lu_w_mat, lu_b_vec,
               res_valid, res_data, res_last, busy, timeout_err
    );
endinterface

// File: rtl/linear_driver.sv
// Sequencer for the linear unit: collects an operand frame word by word, launches the
// unit, waits (with timeout) for its result vector and streams the result out word by word.
module linear_driver #(
    parameter int D_IN    = 4,
    parameter int D_OUT   = 2,
    parameter int DW      = 4,
    parameter int ACC_W   = 2*DW + $clog2(D_IN),
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    linear_driver_if.master bus
);
    localparam int N_WORDS = D_IN + D_OUT*D_IN + D_OUT;
    localparam int W_BASE  = D_IN;
    localparam int B_BASE  = D_IN + D_OUT*D_IN;
    localparam int WCW     = $clog2(N_WORDS);
    localparam int RCW     = (D_OUT > 1) ? $clog2(D_OUT) : 1;
    localparam int TCW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

    state_t                  state_reg;
    logic [WCW-1:0]          wcnt_reg;
    logic [RCW-1:0]          rcnt_reg;
    logic [TCW-1:0]          tcnt_reg;

    logic                    ld_ready_reg;
    logic                    lu_start_reg;
    logic                    lu_in_valid_reg;
    logic                    res_valid_reg;
    logic                    res_last_reg;
    logic                    busy_reg;
    logic                    timeout_err_reg;

    logic signed [DW-1:0]    x_reg [0:D_IN-1];
    logic signed [DW-1:0]    w_reg [0:D_OUT*D_IN-1];
    logic signed [ACC_W-1:0] b_reg [0:D_OUT-1];
    logic signed [ACC_W-1:0] y_reg [0:D_OUT-1];

    logic ld_fire;
    logic capture;

    // ld_ready_reg is high exactly in LOAD, so a handshake implies the LOAD state.
    assign ld_fire = bus.ld_valid & ld_ready_reg;
    assign capture = (state_reg == WAIT) & bus.lu_out_valid;

    genvar gi;

    generate
        for (gi = 0; gi < D_IN; gi++) begin : g_x
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_reg[gi] <= '0;
                end else if (ld_fire && wcnt_reg == WCW'(gi)) begin
                    x_reg[gi] <= $signed(bus.ld_data[DW-1:0]);
                end
            end
            assign bus.lu_in_vec[gi] = x_reg[gi];
        end

        for (gi = 0; gi < D_OUT*D_IN; gi++) begin : g_w
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_reg[gi] <= '0;
                end else if (ld_fire && wcnt_reg == WCW'(W_BASE + gi)) begin
                    w_reg[gi] <= $signed(bus.ld_data[DW-1:0]);
                end
            end
            assign bus.lu_w_mat[gi] = w_reg[gi];
        end

        for (gi = 0; gi < D_OUT; gi++) begin : g_b
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_reg[gi] <= '0;
                end else if (ld_fire && wcnt_reg == WCW'(B_BASE + gi)) begin
                    b_reg[gi] <= $signed(bus.ld_data);
                end
            end
            assign bus.lu_b_vec[gi] = b_reg[gi];
        end

        for (gi = 0; gi < D_OUT; gi++) begin : g_y
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_reg[gi] <= '0;
                end else if (capture) begin
                    y_reg[gi] <= bus.lu_out_vec[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= LOAD;
            wcnt_reg        <= '0;
            rcnt_reg        <= '0;
            tcnt_reg        <= '0;
            ld_ready_reg    <= 1'b1;
            lu_start_reg    <= 1'b0;
            lu_in_valid_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_last_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            lu_start_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (ld_fire) begin
                        if (wcnt_reg == WCW'(N_WORDS-1)) begin
                            wcnt_reg        <= '0;
                            state_reg       <= START;
                            ld_ready_reg    <= 1'b0;
                            lu_start_reg    <= 1'b1;
                            lu_in_valid_reg <= 1'b1;
                            busy_reg        <= 1'b1;
                        end else begin
                            wcnt_reg <= wcnt_reg + WCW'(1);
                        end
                    end
                end
                START: begin
                    tcnt_reg  <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the timeout cycle is still accepted.
                    if (bus.lu_out_valid) begin
                        state_reg       <= DRAIN;
                        lu_in_valid_reg <= 1'b0;
                        res_valid_reg   <= 1'b1;
                        res_last_reg    <= (D_OUT == 1);
                    end else if (tcnt_reg == TCW'(TIMEOUT-1)) begin
                        state_reg       <= LOAD;
                        timeout_err_reg <= 1'b1;
                        lu_in_valid_reg <= 1'b0;
                        ld_ready_reg    <= 1'b1;
                        busy_reg        <= 1'b0;
                    end else begin
                        tcnt_reg <= tcnt_reg + TCW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.res_ready) begin
                        if (rcnt_reg == RCW'(D_OUT-1)) begin
                            rcnt_reg      <= '0;
                            state_reg     <= LOAD;
                            res_valid_reg <= 1'b0;
                            res_last_reg  <= 1'b0;
                            ld_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                        end else begin
                            rcnt_reg     <= rcnt_reg + RCW'(1);
                            res_last_reg <= ((rcnt_reg + RCW'(1)) == RCW'(D_OUT-1));
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign bus.ld_ready    = ld_ready_reg;
    assign bus.lu_start    = lu_start_reg;
    assign bus.lu_in_valid = lu_in_valid_reg;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_data    = y_reg[rcnt_reg];
    assign bus.res_last    = res_last_reg;
    assign bus.busy        = busy_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_linear_driver.sv
// Directed bench for linear_driver with a latency-3 linear-unit model and a result scoreboard.
module tb_linear_driver;
    localparam int D_IN    = 4;
    localparam int D_OUT   = 2;
    localparam int DW      = 4;
    localparam int ACC_W   = 10;
    localparam int TIMEOUT = 8;
    localparam int N_WORDS = D_IN + D_OUT*D_IN + D_OUT;

    logic clk;
    logic rst_n;

    linear_driver_if #(.D_IN(D_IN), .D_OUT(D_OUT), .DW(DW), .ACC_W(ACC_W)) bus();

    linear_driver #(.D_IN(D_IN), .D_OUT(D_OUT), .DW(DW), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Linear-unit model: answers three cycles after lu_start unless disabled.
    logic [2:0] sr;
    logic       lu_en;
    logic       spur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[1:0], bus.lu_start & lu_en};
    end

    assign bus.lu_out_valid = sr[2] | spur;

    always_comb begin : lu_model
        int acc;
        for (int r = 0; r < D_OUT; r++) begin
            acc = int'(bus.lu_b_vec[r]);
            for (int c = 0; c < D_IN; c++)
                acc = acc + int'(bus.lu_w_mat[r*D_IN+c]) * int'(bus.lu_in_vec[c]);
            bus.lu_out_vec[r] = spur ? ACC_W'(99) : ACC_W'(acc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [ACC_W-1:0] q [$];
    logic [ACC_W-1:0] fr [N_WORDS];
    int xv [D_IN];
    int wv [D_OUT*D_IN];
    int bv [D_OUT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic int sx(input logic [ACC_W-1:0] v);
        logic [DW-1:0] lo;
        lo = v[DW-1:0];
        return int'($signed(lo));
    endfunction

    task automatic build_frame(input bit junk);
        for (int i = 0; i < D_IN; i++)
            fr[i] = (ACC_W'(xv[i]) & ACC_W'(15)) | (junk ? ACC_W'(10'h2A0) : '0);
        for (int i = 0; i < D_OUT*D_IN; i++)
            fr[D_IN+i] = (ACC_W'(wv[i]) & ACC_W'(15)) | (junk ? ACC_W'(10'h2A0) : '0);
        for (int i = 0; i < D_OUT; i++)
            fr[D_IN+D_OUT*D_IN+i] = ACC_W'(bv[i]);
    endtask

    task automatic push_expected();
        int acc;
        for (int r = 0; r < D_OUT; r++) begin
            acc = int'($signed(fr[D_IN+D_OUT*D_IN+r]));
            for (int c = 0; c < D_IN; c++)
                acc = acc + sx(fr[D_IN+r*D_IN+c]) * sx(fr[c]);
            q.push_back(ACC_W'(acc));
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic load_word(input logic [ACC_W-1:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        n = 0;
        while (!bus.ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) expire("ld_ready_wait");
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic load_frame(input int gap, input bit push);
        if (push) push_expected();
        for (int i = 0; i < N_WORDS; i++) load_word(fr[i], gap);
        chk("start_pulse", 32'(bus.lu_start), 32'd1);
        chk("busy_start", 32'(bus.busy), 32'd1);
        chk("ld_ready_start", 32'(bus.ld_ready), 32'd0);
        for (int i = 0; i < D_IN; i++) chk($sformatf("in_vec%0d", i), 32'(bus.lu_in_vec[i]), 32'(sx(fr[i])));
        for (int i = 0; i < D_OUT*D_IN; i++) chk($sformatf("w_mat%0d", i), 32'(bus.lu_w_mat[i]), 32'(sx(fr[D_IN+i])));
        for (int i = 0; i < D_OUT; i++) chk($sformatf("b_vec%0d", i), 32'(bus.lu_b_vec[i]), 32'(int'($signed(fr[D_IN+D_OUT*D_IN+i]))));
    endtask

    task automatic drain(input int stall);
        int n;
        logic [ACC_W-1:0] e;
        for (int i = 0; i < D_OUT; i++) begin
            n = 0;
            while (!bus.res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) expire("res_valid_wait");
            if (i == 0 && stall > 0) begin
                bus.res_ready = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    chk("res_hold", 32'(bus.res_data), 32'(q[0]));
                    chk("busy_hold", 32'(bus.busy), 32'd1);
                    chk("ld_ready_hold", 32'(bus.ld_ready), 32'd0);
                end
            end
            e = q.pop_front();
            chk($sformatf("res_data%0d", i), 32'(bus.res_data), 32'(e));
            chk($sformatf("res_last%0d", i), 32'(bus.res_last), 32'(i == D_OUT-1));
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
        end
        chk("ld_ready_after", 32'(bus.ld_ready), 32'd1);
        chk("res_valid_after", 32'(bus.res_valid), 32'd0);
    endtask

    // Called at the START falling edge; counts operand-valid cycles.
    task automatic finish_frame(input bit spur_start, input int stall, input bit to_case);
        int cnt;
        int starts;
        int resv;
        cnt = 0;
        starts = 0;
        resv = 0;
        if (spur_start) spur = 1'b1;
        while (bus.lu_in_valid && cnt < 50) begin
            cnt++;
            if (bus.lu_start) starts++;
            if (bus.res_valid) resv++;
            @(negedge clk);
            spur = 1'b0;
        end
        chk("start_count", 32'(starts), 32'd1);
        chk("res_valid_in_wait", 32'(resv), 32'd0);
        if (to_case) begin
            chk("in_valid_cycles_to", 32'(cnt), 32'(TIMEOUT + 1));
            chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
            chk("ld_ready_to", 32'(bus.ld_ready), 32'd1);
            chk("res_valid_to", 32'(bus.res_valid), 32'd0);
            chk("busy_to", 32'(bus.busy), 32'd0);
        end else begin
            chk("in_valid_cycles", 32'(cnt), 32'd4);
            chk("res_valid_first", 32'(bus.res_valid), 32'd1);
            drain(stall);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd1);
        chk({tag, "_lu_start"}, 32'(bus.lu_start), 32'd0);
        chk({tag, "_in_valid"}, 32'(bus.lu_in_valid), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_last"}, 32'(bus.res_last), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
        chk({tag, "_x0"}, 32'(bus.lu_in_vec[0]), 32'd0);
        chk({tag, "_b1"}, 32'(bus.lu_b_vec[1]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        rst_n = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_data = '0;
        bus.res_ready = 1'b0;
        lu_en = 1'b1;
        spur = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame.
        xv = '{1, 2, 3, 4};
        wv = '{1, 1, 1, 1, -1, 0, 0, 2};
        bv = '{5, -3};
        build_frame(1'b0);
        load_frame(0, 1'b1);
        finish_frame(1'b0, 0, 1'b0);
        $display("txn basic frame done");

        // Load gaps plus junk in the discarded upper bits.
        build_frame(1'b1);
        load_frame(2, 1'b1);
        finish_frame(1'b0, 0, 1'b0);
        $display("txn load backpressure frame done");

        // Result backpressure with a negative result.
        xv = '{3, -2, 1, 0};
        wv = '{2, 2, 2, 2, 1, -1, 1, -1};
        bv = '{-7, 20};
        build_frame(1'b0);
        load_frame(0, 1'b1);
        finish_frame(1'b0, 5, 1'b0);
        $display("txn result backpressure frame done");

        // Timeout, then a normal frame with the sticky flag.
        lu_en = 1'b0;
        load_frame(0, 1'b0);
        finish_frame(1'b0, 0, 1'b1);
        lu_en = 1'b1;
        load_frame(1, 1'b1);
        finish_frame(1'b0, 0, 1'b0);
        chk("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
        $display("txn timeout then recovery done");

        // Spurious result pulses in LOAD and START.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_load_res_valid", 32'(bus.res_valid), 32'd0);
        chk("spur_load_ld_ready", 32'(bus.ld_ready), 32'd1);
        load_frame(0, 1'b1);
        finish_frame(1'b1, 0, 1'b0);
        $display("txn spurious result frame done");

        // Asynchronous reset in WAIT.
        load_frame(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_in_valid", 32'(bus.lu_in_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.lu_start || bus.res_valid) starts++;
        end
        chk("no_start_after_reset", 32'(starts), 32'd0);
        xv = '{-8, 7, -1, 3};
        wv = '{1, 1, 1, 1, -8, 7, 2, -3};
        bv = '{100, -50};
        build_frame(1'b0);
        load_frame(0, 1'b1);
        finish_frame(1'b0, 0, 1'b0);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("txn post-reset frame done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/linear_driver.md
# linear_driver

Initiator-side sequencer for the `linear_unit` operand/result handshake. It has two streams, a load stream and a result stream, both using valid/ready.

- **Load side:** accepts x, W and b words one at a time on the load stream and registers them into the flattened operand arrays. It then issues the `start` pulse and holds `in_valid` until the unit returns `out_valid`.
- **Result side:** captures the result vector and serializes it on the result stream.

The block sits between the operand memory/DMA and the linear unit, so callers never deal with the unit's array-wide ports.

## Interface
- `D_IN`, default 4: input vector length.
- `D_OUT`, default 2: output vector length.
- `DW`, default 4: x/W element width (signed).
- `ACC_W`, default 2*DW+$clog2(D_IN): bias/result width (signed).
- `TIMEOUT`, default 64: maximum WAIT cycles before abort.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ld_valid`  in  1  load word valid.
- `ld_ready`  out  1  load word accepted when both are high.
- `ld_data`  in  ACC_W  load word; x/W use `[DW-1:0]`, bias uses the full width.
- `lu_start`  out  1  one-cycle start pulse to the linear unit.
- `lu_in_valid`  out  1  operands valid to the linear unit.
- `lu_in_vec`  out  DW x [0:D_IN-1]  signed x.
- `lu_w_mat`  out  DW x [0:D_OUT*D_IN-1]  signed W, row-major.
- `lu_b_vec`  out  ACC_W x [0:D_OUT-1]  signed bias.
- `lu_out_valid`  in  1  result pulse from the linear unit.
- `lu_out_vec`  in  ACC_W x [0:D_OUT-1]  result vector.
- `res_valid`  out  1  result word valid.
- `res_ready`  in  1  downstream accepts.
- `res_data`  out  ACC_W  result word.
- `res_last`  out  1  high with the final result word (index D_OUT-1).
- `busy`  out  1  state != LOAD.
- `timeout_err`  out  1  sticky; set on WAIT timeout, cleared only by reset.

## Operation
- Load frame: `N_WORDS = D_IN + D_OUT*D_IN + D_OUT`, in this order:
  - x[0..D_IN-1];
  - W[0..D_OUT*D_IN-1];
  - b[0..D_OUT-1].
- Word counter `wcnt` in the range 0..N_WORDS-1 selects the destination register.
- FSM states: LOAD, START, WAIT, DRAIN. Reset enters LOAD.
- **LOAD:**
  - `ld_ready`=1.
  - Each handshake writes `ld_data` to the element selected by `wcnt` and increments `wcnt`.
  - On the handshake with `wcnt`=N_WORDS-1, clear `wcnt` and go to START.
  - `ld_valid` without `ld_ready` (any other state) is ignored; no word is consumed.
- **START (1 cycle):**
  - `lu_start`=1, `lu_in_valid`=1.
  - Clear the timeout counter; go to WAIT.
  - `lu_out_valid` in this cycle is ignored.
- **WAIT:**
  - `lu_in_valid`=1; the counter increments each cycle.
  - On `lu_out_valid`, register all `lu_out_vec` elements into the result buffer and go to DRAIN.
  - Otherwise, when the counter reaches TIMEOUT-1, set `timeout_err` and go to LOAD with no result emitted.
  - If `lu_out_valid` and the timeout fall in the same cycle, `lu_out_valid` wins.
- **DRAIN:**
  - `res_valid`=1, `res_data`=buffer[`rcnt`], `res_last`=(`rcnt`==D_OUT-1).
  - On a handshake, increment `rcnt`.
  - On the handshake of the last word, clear `rcnt` and go to LOAD.
  - `res_data` is stable while `res_valid`=1 and `res_ready`=0.
- Operand registers change only on LOAD handshakes, so `lu_*` operands are stable from START through WAIT.
- `lu_out_valid` outside WAIT is ignored.
- x/W elements are the signed low DW bits of `ld_data`; upper bits are discarded. Bias is stored as full signed ACC_W.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state LOAD; `wcnt`, `rcnt`, timeout counter = 0.
  - Operand and result registers = 0.
  - Outputs: `ld_ready`=1, `lu_start`=0, `lu_in_valid`=0, `res_valid`=0, `res_last`=0, `busy`=0, `timeout_err`=0.
- Reset mid-frame (any state) discards partial loads and pending results. There is no `lu_start` after release until a full frame has been reloaded.
- All control outputs decode from registered state; there is no combinational path from `ld_valid`/`res_ready` to any output.
- `lu_start` rises the cycle after the final load handshake.
- The first `res_valid` is high the cycle after the `lu_out_valid` sample.
- Minimum frame turnaround with unstalled streams: N_WORDS + 1 + WAIT + D_OUT cycles.
- `ld_ready` returns high the cycle after the last result handshake.

## Test plan
- **Basic result, D_IN=4, D_OUT=2, DW=4, ACC_W=10, LU model of latency 3:**
  - Stimulus: load x=[1,2,3,4], W=[1,1,1,1,-1,0,0,2], b=[5,-3].
  - Response: one `lu_start` pulse; `lu_in_valid` high for 4 cycles; res stream 15 then 4; `res_last` on the second word only.
- **Load backpressure:** insert 2-cycle `ld_valid` gaps between words → identical operands on `lu_*` and identical results 15, 4.
- **Result backpressure:** hold `res_ready`=0 for 5 cycles in DRAIN → `res_data`=15 held stable, no advance; `busy`=1; `ld_ready`=0.
- **Timeout, TIMEOUT=8:** LU model never responds → `timeout_err`=1 after 8 WAIT cycles, state back to LOAD (`ld_ready`=1), no `res_valid`. The next frame completes normally and `timeout_err` stays 1.
- **Spurious/late result:** pulse `lu_out_valid` during LOAD and START → ignored, no `res_valid`, result buffer unchanged.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT → all outputs at their reset values asynchronously. After release, load a fresh frame with x=[-8,...] → correct results.
